// File: rtl/dfs_pkg.sv
// rtl/dfs_pkg.sv - shared FSM state type and frequency-table lookup for the DFS request controller
package dfs_pkg;

    localparam int DFS_TBL_BITS  = 4096;
    localparam int DFS_WORD_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_WAIT_LOCK,
        ST_DWELL
    } dfs_ctrl_state_t;

    // Table is zero-extended to a fixed width so one function serves every instance.
    function automatic logic [DFS_WORD_BITS-1:0] dfs_tbl_word(
        input logic [DFS_TBL_BITS-1:0] freqs,
        input logic [31:0]             idx,
        input int unsigned             dw
    );
        return DFS_WORD_BITS'(freqs >> (idx * dw));
    endfunction

endpackage

// File: rtl/dfs_freq_chan.sv
// rtl/dfs_freq_chan.sv - one DFS channel: FIFO drain, table lookup, request/ack/lock/dwell sequencing
module dfs_freq_chan
    import dfs_pkg::*;
#(
    parameter int DATA_WIDTH  = 13,
    parameter int N_FREQ      = 20,
    parameter int IDX_WIDTH   = 8,
    parameter logic [N_FREQ*DATA_WIDTH-1:0] FREQS = '0,
    parameter int DEFAULT_IDX = 0,
    parameter int RAMP        = 0,
    parameter int MIN_DWELL   = 64,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_WIDTH-1:0]  freq_data_in,
    input  logic                  freq_empty_in,
    output logic                  freq_rd_o,
    output logic                  dfs_en_o,
    output logic [DATA_WIDTH-1:0] dfs_data_o,
    input  logic                  dfs_ack_i,
    input  logic                  dfs_locked_i,
    output logic [IDX_WIDTH-1:0]  cur_idx_o,
    output logic                  busy_o,
    input  logic                  err_clr_i,
    output logic                  err_idx_o,
    output logic                  err_tmo_o
);

    localparam int CNT_MAX = (ACK_TIMEOUT > MIN_DWELL) ? ACK_TIMEOUT : MIN_DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_WIDTH-1:0]  DEF_IDX  = IDX_WIDTH'(DEFAULT_IDX);
    localparam logic [DATA_WIDTH-1:0] DEF_WORD =
        DATA_WIDTH'(dfs_tbl_word(DFS_TBL_BITS'(FREQS), 32'(DEFAULT_IDX), DATA_WIDTH));

    dfs_ctrl_state_t       state_q, state_d;
    logic [IDX_WIDTH-1:0]  cur_q, cur_d, tgt_q, tgt_d, nxt_q, nxt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  err_idx_q, err_idx_d, err_tmo_q, err_tmo_d;
    logic                  pop;
    logic                  idx_bad;
    logic [IDX_WIDTH-1:0]  req_tgt, step_idx;
    logic [DATA_WIDTH-1:0] step_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= DEF_IDX;
            tgt_q     <= DEF_IDX;
            nxt_q     <= DEF_IDX;
            data_q    <= DEF_WORD;
            cnt_q     <= '0;
            err_idx_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            nxt_q     <= nxt_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_idx_q <= err_idx_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    // A pending ramp target outranks the FIFO head, so the head is only consulted when cur == tgt.
    always_comb begin
        req_tgt = (cur_q != tgt_q) ? tgt_q : freq_data_in;
        if (RAMP != 0) begin
            step_idx = (req_tgt > cur_q) ? cur_q + 1'b1 : cur_q - 1'b1;
        end else begin
            step_idx = req_tgt;
        end
        step_word = DATA_WIDTH'(dfs_tbl_word(DFS_TBL_BITS'(FREQS), 32'(step_idx), DATA_WIDTH));
        idx_bad   = 32'(freq_data_in) >= 32'(N_FREQ);
        cnt_inc   = cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        nxt_d     = nxt_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_idx_d = err_idx_q & ~err_clr_i;
        err_tmo_d = err_tmo_q & ~err_clr_i;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cur_q != tgt_q) begin
                    nxt_d   = step_idx;
                    data_d  = step_word;
                    state_d = ST_REQ;
                end else if (!freq_empty_in) begin
                    pop = 1'b1;
                    if (idx_bad) begin
                        err_idx_d = 1'b1;
                    end else if (freq_data_in != cur_q) begin
                        tgt_d   = freq_data_in;
                        nxt_d   = step_idx;
                        data_d  = step_word;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Counter starts at 1 so it measures cycles since the request strobe.
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (dfs_ack_i) begin
                    cur_d   = nxt_q;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    err_tmo_d = 1'b1;
                    tgt_d     = cur_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (dfs_locked_i) begin
                    cnt_d   = '0;
                    state_d = (MIN_DWELL == 0) ? ST_IDLE : ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt_inc == CNT_W'(MIN_DWELL)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        freq_rd_o = pop;
        dfs_en_o  = (state_q == ST_REQ);
        busy_o    = (state_q != ST_IDLE);
    end

    assign dfs_data_o = data_q;
    assign cur_idx_o  = cur_q;
    assign err_idx_o  = err_idx_q;
    assign err_tmo_o  = err_tmo_q;

endmodule

// File: rtl/dfs_freq_ctrl.sv
// rtl/dfs_freq_ctrl.sv - multi-channel DFS frequency-request controller; one independent channel per slice
module dfs_freq_ctrl #(
    parameter int N_CH        = 2,
    parameter int DATA_WIDTH  = 13,
    parameter int N_FREQ      = 20,
    parameter int IDX_WIDTH   = 8,
    parameter logic [N_FREQ*DATA_WIDTH-1:0] FREQS = '0,
    parameter int DEFAULT_IDX = 0,
    parameter int RAMP        = 0,
    parameter int MIN_DWELL   = 64,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*IDX_WIDTH-1:0]  freq_data_in,
    input  logic [N_CH-1:0]            freq_empty_in,
    output logic [N_CH-1:0]            freq_rd_o,
    output logic [N_CH-1:0]            dfs_en_o,
    output logic [N_CH*DATA_WIDTH-1:0] dfs_data_o,
    input  logic [N_CH-1:0]            dfs_ack_i,
    input  logic [N_CH-1:0]            dfs_locked_i,
    output logic [N_CH*IDX_WIDTH-1:0]  cur_idx_o,
    output logic [N_CH-1:0]            busy_o,
    input  logic [N_CH-1:0]            err_clr_i,
    output logic [N_CH-1:0]            err_idx_o,
    output logic [N_CH-1:0]            err_tmo_o
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dfs_freq_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .N_FREQ     (N_FREQ),
            .IDX_WIDTH  (IDX_WIDTH),
            .FREQS      (FREQS),
            .DEFAULT_IDX(DEFAULT_IDX),
            .RAMP       (RAMP),
            .MIN_DWELL  (MIN_DWELL),
            .ACK_TIMEOUT(ACK_TIMEOUT)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .freq_data_in (freq_data_in[c*IDX_WIDTH +: IDX_WIDTH]),
            .freq_empty_in(freq_empty_in[c]),
            .freq_rd_o    (freq_rd_o[c]),
            .dfs_en_o     (dfs_en_o[c]),
            .dfs_data_o   (dfs_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
            .dfs_ack_i    (dfs_ack_i[c]),
            .dfs_locked_i (dfs_locked_i[c]),
            .cur_idx_o    (cur_idx_o[c*IDX_WIDTH +: IDX_WIDTH]),
            .busy_o       (busy_o[c]),
            .err_clr_i    (err_clr_i[c]),
            .err_idx_o    (err_idx_o[c]),
            .err_tmo_o    (err_tmo_o[c])
        );
    end

endmodule

// File: tb/tb_dfs_freq_ctrl.sv
// tb/tb_dfs_freq_ctrl.sv - directed self-checking bench for dfs_freq_ctrl (jump and ramp instances)
module tb_dfs_freq_ctrl;

    localparam int DW = 13;
    localparam int IW = 8;
    localparam int NF = 20;

    // Table entry i = 100 + 7*i
    function automatic logic [NF*DW-1:0] mk_freqs();
        logic [NF*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NF; i++) v[i*DW +: DW] = DW'(100 + 7 * i);
        return v;
    endfunction
    localparam logic [NF*DW-1:0] FREQS = mk_freqs();

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*IW-1:0] fd;
    logic [1:0]      fe, rd, en, ack, locked, busy, clr, eidx, etmo;
    logic [2*DW-1:0] data;
    logic [2*IW-1:0] cur;

    logic [IW-1:0]   r_fd;
    logic            r_fe, r_rd, r_en, r_ack, r_locked, r_busy, r_clr, r_eidx, r_etmo;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   r_cur;

    int checks = 0;
    int errors = 0;
    int r_pops = 0;
    int ramp_word [4] = '{128, 135, 142, 149};

    dfs_freq_ctrl #(
        .N_CH(2), .DATA_WIDTH(DW), .N_FREQ(NF), .IDX_WIDTH(IW), .FREQS(FREQS),
        .DEFAULT_IDX(0), .RAMP(0), .MIN_DWELL(4), .ACK_TIMEOUT(16)
    ) u_dut (
        .clk(clk), .rst(rst), .freq_data_in(fd), .freq_empty_in(fe), .freq_rd_o(rd),
        .dfs_en_o(en), .dfs_data_o(data), .dfs_ack_i(ack), .dfs_locked_i(locked),
        .cur_idx_o(cur), .busy_o(busy), .err_clr_i(clr), .err_idx_o(eidx), .err_tmo_o(etmo)
    );

    dfs_freq_ctrl #(
        .N_CH(1), .DATA_WIDTH(DW), .N_FREQ(NF), .IDX_WIDTH(IW), .FREQS(FREQS),
        .DEFAULT_IDX(3), .RAMP(1), .MIN_DWELL(4), .ACK_TIMEOUT(16)
    ) u_ramp (
        .clk(clk), .rst(rst), .freq_data_in(r_fd), .freq_empty_in(r_fe), .freq_rd_o(r_rd),
        .dfs_en_o(r_en), .dfs_data_o(r_data), .dfs_ack_i(r_ack), .dfs_locked_i(r_locked),
        .cur_idx_o(r_cur), .busy_o(r_busy), .err_clr_i(r_clr), .err_idx_o(r_eidx), .err_tmo_o(r_etmo)
    );

    always @(negedge clk) if (r_rd) r_pops <= r_pops + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int viol;
        int first;
        int found;

        fd = '0; fe = 2'b11; ack = '0; locked = '0; clr = '0;
        r_fd = '0; r_fe = 1'b1; r_ack = 1'b0; r_locked = 1'b0; r_clr = 1'b0;
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;

        // Reset release with empty FIFOs
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rd != 2'b00 || en != 2'b00 || r_rd || r_en) viol++;
        end
        chk("quiet_100", 32'(viol), 32'd0);
        chk("rst_cur", 32'(cur), 32'd0);
        chk("rst_data_ch0", 32'(data[DW-1:0]), 32'd100);
        chk("rst_data_ch1", 32'(data[2*DW-1:DW]), 32'd100);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'({eidx, etmo}), 32'd0);
        chk("ramp_rst_cur", 32'(r_cur), 32'd3);
        chk("ramp_rst_data", 32'(r_data), 32'd121);

        // Jump to index 5 on ch0
        fd[IW-1:0] = 8'd5; fe[0] = 1'b0; #1;
        chk("pop5_rd", 32'(rd), 32'd1);
        step(); fe[0] = 1'b1; #1;
        chk("req5_en", 32'(en), 32'd1);
        chk("req5_data", 32'(data[DW-1:0]), 32'd135);
        chk("req5_rd", 32'(rd), 32'd0);
        step();
        chk("wack_en", 32'(en), 32'd0);
        chk("wack_busy", 32'(busy), 32'd1);
        step(); step(); ack[0] = 1'b1; #1;
        chk("cur_before_ack", 32'(cur[IW-1:0]), 32'd0);
        step(); ack[0] = 1'b0;
        chk("cur_after_ack", 32'(cur[IW-1:0]), 32'd5);
        chk("data_held", 32'(data[DW-1:0]), 32'd135);
        for (int k = 0; k < 9; k++) step();
        locked[0] = 1'b1; fd[IW-1:0] = 8'd9; fe[0] = 1'b0;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            step(); locked[0] = 1'b0; #1;
            if (rd[0]) first = k;
        end
        chk("dwell_pop_delay", 32'(first), 32'd5);
        step(); fe[0] = 1'b1; #1;
        chk("req9_en", 32'(en), 32'd1);
        chk("req9_data", 32'(data[DW-1:0]), 32'd163);
        step(); ack[0] = 1'b1;
        step(); ack[0] = 1'b0;
        chk("cur9", 32'(cur[IW-1:0]), 32'd9);
        locked[0] = 1'b1; step(); locked[0] = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Invalid index and sticky error
        fd[IW-1:0] = 8'd25; fe[0] = 1'b0; #1;
        chk("bad_pop_rd", 32'(rd), 32'd1);
        step(); fe[0] = 1'b1; #1;
        chk("bad_no_en", 32'(en), 32'd0);
        chk("bad_err_idx", 32'(eidx), 32'd1);
        chk("bad_not_busy", 32'(busy), 32'd0);
        clr[0] = 1'b1; step(); clr[0] = 1'b0; #1;
        chk("err_idx_clr", 32'(eidx), 32'd0);
        fd[IW-1:0] = 8'd30; fe[0] = 1'b0; clr[0] = 1'b1; step();
        fe[0] = 1'b1; clr[0] = 1'b0; #1;
        chk("err_set_wins", 32'(eidx), 32'd1);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;

        // Ack timeout, then the next queued index is served
        fd[IW-1:0] = 8'd2; fe[0] = 1'b0; #1;
        chk("pop2_rd", 32'(rd), 32'd1);
        step(); fd[IW-1:0] = 8'd11; #1;
        chk("req2_data", 32'(data[DW-1:0]), 32'd114);
        first = 0;
        for (int k = 1; k <= 30 && first == 0; k++) begin
            step();
            if (etmo[0]) first = k;
        end
        chk("tmo_delay", 32'(first), 32'd16);
        chk("tmo_cur_kept", 32'(cur[IW-1:0]), 32'd9);
        chk("tmo_next_pop", 32'(rd), 32'd1);
        step(); fe[0] = 1'b1; #1;
        chk("req11_en", 32'(en), 32'd1);
        chk("req11_data", 32'(data[DW-1:0]), 32'd177);
        step(); ack[0] = 1'b1;
        step(); ack[0] = 1'b0;
        chk("cur11", 32'(cur[IW-1:0]), 32'd11);
        locked[0] = 1'b1; step(); locked[0] = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Both channels at once, then reset while ch0 waits for ack
        fd = {8'd4, 8'd6}; fe = 2'b00; #1;
        chk("dual_rd", 32'(rd), 32'd3);
        step(); fe = 2'b11; #1;
        chk("dual_en", 32'(en), 32'd3);
        chk("dual_data_ch0", 32'(data[DW-1:0]), 32'd142);
        chk("dual_data_ch1", 32'(data[2*DW-1:DW]), 32'd128);
        step(); ack = 2'b10;
        step(); ack = 2'b00;
        chk("dual_cur_ch1", 32'(cur[2*IW-1:IW]), 32'd4);
        chk("dual_cur_ch0", 32'(cur[IW-1:0]), 32'd11);
        chk("dual_busy", 32'(busy), 32'd3);
        chk("pre_rst_tmo", 32'(etmo), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_strobes", 32'({rd, en}), 32'd0);
        chk("mrst_cur", 32'(cur), 32'd0);
        chk("mrst_data", 32'(data), 32'({13'd100, 13'd100}));
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'({eidx, etmo}), 32'd0);
        r_pops = 0;

        // Ramp from 3 to 7
        r_fd = 8'd7; r_fe = 1'b0; #1;
        chk("ramp_pop", 32'(r_rd), 32'd1);
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int k = 0; k < 30 && found == 0; k++) begin
                step(); r_fe = 1'b1;
                if (r_en) found = 1;
            end
            chk("ramp_en_seen", 32'(found), 32'd1);
            chk("ramp_data", 32'(r_data), 32'(ramp_word[i]));
            step(); r_ack = 1'b1;
            step(); r_ack = 1'b0;
            chk("ramp_cur", 32'(r_cur), 32'(4 + i));
            r_locked = 1'b1; step(); r_locked = 1'b0;
        end
        viol = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (r_en) viol++;
        end
        chk("ramp_no_extra_en", 32'(viol), 32'd0);
        chk("ramp_pops", 32'(r_pops), 32'd1);
        chk("ramp_idle", 32'(r_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfs_freq_ctrl.md
# dfs_freq_ctrl

Parametrised multi-channel frequency-request controller for the DFS clock managers. It drains one frequency-index FIFO per channel and translates each index into a DFS divider word through a shared lookup table. It drives the DFS `en`/`data` request and tracks the DFS `ack` and `locked` responses. Compared with the single-channel constant-frequency requester, it adds:
- `N_CH` independent channels;
- optional one-step ramping toward a target;
- a minimum dwell time between changes;
- ack timeout;
- invalid-index rejection with sticky error flags.

## Interface
Parameters:
- `N_CH`, 2: number of independent DFS channels.
- `DATA_WIDTH`, 13: DFS data word width.
- `N_FREQ`, 20: number of table entries.
- `IDX_WIDTH`, 8: width of a requested index.
- `FREQS`, `N_FREQ*DATA_WIDTH` bits: the table. Entry i sits at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `DEFAULT_IDX`, 0: index assumed active after reset.
- `RAMP`, 0: 0 = jump directly to the target; 1 = step one table index per change.
- `MIN_DWELL`, 64: cycles held after lock before the next change (0 allowed).
- `ACK_TIMEOUT`, 4096: cycles allowed from `dfs_en_o` to `dfs_ack_i`.

Ports:
- `clk`  in  1  single clock; every flop uses this clock.
- `rst`  in  1  synchronous, active-high reset.
- `freq_data_in`  in  `N_CH*IDX_WIDTH`  per-channel FIFO head, first-word-fall-through.
- `freq_empty_in`  in  `N_CH`  per-channel FIFO empty.
- `freq_rd_o`  out  `N_CH`  one-cycle pop strobe.
- `dfs_en_o`  out  `N_CH`  one-cycle request strobe to DFS.
- `dfs_data_o`  out  `N_CH*DATA_WIDTH`  table word; held stable from the request until ack.
- `dfs_ack_i`  in  `N_CH`  DFS accepted request.
- `dfs_locked_i`  in  `N_CH`  DFS output clock locked.
- `cur_idx_o`  out  `N_CH*IDX_WIDTH`  index last acknowledged.
- `busy_o`  out  `N_CH`  channel not in IDLE.
- `err_clr_i`  in  `N_CH`  clears that channel's sticky errors.
- `err_idx_o`  out  `N_CH`  sticky: index ≥ `N_FREQ` was received.
- `err_tmo_o`  out  `N_CH`  sticky: ack timeout.

## Operation
Each channel runs an independent FSM: IDLE, REQ, WAIT_ACK, WAIT_LOCK, DWELL. All registers are per channel.

- **IDLE**
  - If `cur != tgt`: compute the next index. With `RAMP=1` it is `cur±1` toward `tgt`; otherwise it is `tgt`. Go to REQ.
  - Else, if `freq_empty_in` is low: pulse `freq_rd_o` and sample `freq_data_in` in the same cycle.
    - Index ≥ `N_FREQ`: discard it, set `err_idx`, stay in IDLE.
    - Index == `cur`: discard it, no DFS request.
    - Otherwise: latch it as `tgt`.
  - The FIFO is never popped while `cur != tgt`. This gives no preemption and keeps the request order.
- **REQ**: assert `dfs_en_o` for exactly one cycle with `dfs_data_o = FREQS[next]`, then go to WAIT_ACK.
- **WAIT_ACK**
  - On `dfs_ack_i` high: set `cur = next`, go to WAIT_LOCK.
  - On timeout (counter reaches `ACK_TIMEOUT`): set `err_tmo`, set `tgt = cur` (the pending target is abandoned), go to IDLE.
- **WAIT_LOCK**: wait for `dfs_locked_i` high, then go to DWELL. There is no timeout in this state.
- **DWELL**: count `MIN_DWELL` cycles, then go to IDLE. With `MIN_DWELL=0`, DWELL lasts 0 cycles (WAIT_LOCK goes straight to IDLE).

Sticky errors:
- Cleared by `err_clr_i`.
- A set and a clear in the same cycle: set wins.

## Timing
- **Reset values**:
  - all strobes 0; `dfs_data_o` = `FREQS[DEFAULT_IDX]`;
  - `cur_idx_o` = `DEFAULT_IDX`; `tgt` = `DEFAULT_IDX`;
  - `busy_o` 0; errors 0; FSM IDLE.
- No request is issued on reset exit.
- **Latency**: pop in cycle T; `dfs_en_o` in T+1; the earliest ack is accepted in T+2 (ack is ignored in the REQ cycle); `cur_idx_o` updates in the cycle after the ack.
- **Next change** after `dfs_locked_i` is seen high: the earliest pop/request is `MIN_DWELL+1` cycles later.
- **Ramp**: a channel stepping from 3 to 7 issues 4 requests; each waits for ack, lock and dwell.
- **Reset mid-operation** (any state): on the next edge all state returns to reset values; no strobe is emitted in that cycle.
- **Channels**: fully independent; simultaneous activity on all channels is legal.
- **Widths**: counters are sized with `$clog2(MAX+1)`. Index compares are unsigned at `IDX_WIDTH`.

## Structure
- Package `dfs_pkg`:
  - FSM state enum `dfs_ctrl_state_t`;
  - helper function `dfs_tbl_word(FREQS, idx)`.
- Sub-module `dfs_freq_chan`: one channel FSM with its counters and error bits.
- Top level: a generate loop over `N_CH` that slices the flattened buses.

## Test plan
- Reset release with an empty FIFO → no `freq_rd_o`/`dfs_en_o` for 100 cycles; `cur_idx_o=0`; `dfs_data_o=FREQS[0]`.
- Push index 5 (`RAMP=0`), ack 3 cycles after `en`, lock 10 cycles later → one `en` with `FREQS[5]`; `cur_idx_o=5`; next pop exactly `MIN_DWELL+1` cycles after lock.
- `RAMP=1`, `cur=3`, push 7 → 4 requests for indices 4, 5, 6, 7; only one FIFO pop.
- Push 25 (`N_FREQ=20`) → popped, no `en`, `err_idx_o=1`. Then `err_clr_i` → 0. Then set and clear in the same cycle → stays 1.
- Withhold ack → `err_tmo_o` rises `ACK_TIMEOUT` cycles after `en`; `cur_idx_o` unchanged; the next queued index is served.
- Two channels requesting simultaneously, plus `rst` asserted mid-WAIT_ACK on channel 0 → channel 1 is unaffected before the reset; all outputs are at reset values one edge after `rst`.
